// File: rtl/mips_pkg.sv
// Shared pipeline types and sizes for the decode-stage hazard scoreboard.
package mips_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic              uses_rt;
    logic              writes;
  } issue_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [REG_NUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stalled cycles; raises a sticky timeout at STALL_LIMIT.
module stall_watchdog #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clr,
  output logic timeout
);

  localparam int unsigned CW = 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Saturating run-length counter; any non-stalled cycle restarts it.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (!clr && count_en) begin
      cnt_d = (cnt_q == CW'(STALL_LIMIT)) ? cnt_q : cnt_q + CW'(1);
    end
    if (cnt_d == CW'(STALL_LIMIT)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-busy scoreboard for decode: RAW/WAW stall generation, drain/halt
// control and a stall watchdog.
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic              issue_uses_rt,
  input  logic [REG_AW-1:0] issue_dest,
  input  logic              issue_writes,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              flush,
  input  logic              drain_req,
  input  logic              resume,
  output logic              stall,
  output logic              issue_fire,
  output logic [REG_NUM-1:0] busy_vec,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              drain_done,
  output logic              timeout
);

  sb_state_e          state_q, state_d;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               drain_done_q, drain_done_d;
  logic               run_c;
  logic               hazard_c;
  issue_t             iss;

  always_comb begin
    iss.rs      = issue_rs;
    iss.rt      = issue_rt;
    iss.dest    = issue_dest;
    iss.uses_rt = issue_uses_rt;
    iss.writes  = issue_writes;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (drain_req)      state_d = ST_DRAIN;
      ST_DRAIN:  if (busy_q == '0)   state_d = ST_HALTED;
      ST_HALTED: if (resume)         state_d = ST_RUN;
      default:                       state_d = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_c        = (state_q == ST_RUN);
    drain_done_d = (state_d == ST_HALTED);
  end

  // Hazard reads registered busy bits only: a write-back frees its register
  // for issue one cycle later, matching register-file write-then-read.
  always_comb begin
    hazard_c = ((iss.rs != '0) && busy_q[iss.rs])
            || (iss.uses_rt && (iss.rt != '0) && busy_q[iss.rt])
            || (iss.writes && (iss.dest != '0) && busy_q[iss.dest]);
    stall      = !reset && issue_valid && (hazard_c || !run_c);
    issue_fire = !reset && issue_valid && !stall;
  end

  // Clear, then set (set wins), then flush (overrides both).
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_dest != '0)) busy_d[wb_dest] = 1'b0;
    if (issue_fire && iss.writes && (iss.dest != '0)) busy_d[iss.dest] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
    pend_d    = popcount(busy_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      pend_q       <= '0;
      drain_done_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      drain_done_q <= drain_done_d;
    end
  end

  stall_watchdog #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .count_en (run_c && stall),
    .clr      (flush),
    .timeout  (timeout)
  );

  assign busy_vec    = busy_q;
  assign pending_cnt = pend_q;
  assign drain_done  = drain_done_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a rule-level reference model.
module tb_hazard_scoreboard;

  localparam int unsigned LIMIT = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic        clk, reset;
  logic        issue_valid, issue_uses_rt, issue_writes;
  logic [4:0]  issue_rs, issue_rt, issue_dest;
  logic        wb_valid, flush, drain_req, resume;
  logic [4:0]  wb_dest;
  logic        stall, issue_fire, drain_done, timeout;
  logic [31:0] busy_vec;
  logic [5:0]  pending_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rt(issue_uses_rt), .issue_dest(issue_dest),
    .issue_writes(issue_writes), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .flush(flush), .drain_req(drain_req), .resume(resume),
    .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .pending_cnt(pending_cnt), .drain_done(drain_done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending-register set, mode, stall run length, sticky flag.
  logic [31:0] m_busy, m_busy_n;
  int          m_state, m_state_n, m_wd, m_wd_n;
  logic        m_to, m_to_n, m_haz, m_stall, m_fire;

  always_comb begin
    m_haz = (issue_rs != 0 && m_busy[issue_rs])
         || (issue_uses_rt && issue_rt != 0 && m_busy[issue_rt])
         || (issue_writes && issue_dest != 0 && m_busy[issue_dest]);
    m_stall = !reset && issue_valid && (m_haz || m_state != M_RUN);
    m_fire  = !reset && issue_valid && !m_stall;
    m_busy_n = m_busy;
    if (wb_valid && wb_dest != 0) m_busy_n[wb_dest] = 1'b0;
    if (m_fire && issue_writes && issue_dest != 0) m_busy_n[issue_dest] = 1'b1;
    if (flush) m_busy_n = 32'd0;
    m_state_n = m_state;
    if (m_state == M_RUN && drain_req) m_state_n = M_DRAIN;
    else if (m_state == M_DRAIN && m_busy == 32'd0) m_state_n = M_HALT;
    else if (m_state == M_HALT && resume) m_state_n = M_RUN;
    if (!flush && m_state == M_RUN && m_stall)
      m_wd_n = (m_wd >= int'(LIMIT)) ? int'(LIMIT) : m_wd + 1;
    else
      m_wd_n = 0;
    m_to_n = m_to || (m_wd_n == int'(LIMIT));
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 32'd0; m_state <= M_RUN; m_wd <= 0; m_to <= 1'b0;
    end else begin
      m_busy <= m_busy_n; m_state <= m_state_n; m_wd <= m_wd_n; m_to <= m_to_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m.stall",       32'(stall),       32'(m_stall));
    chk("m.issue_fire",  32'(issue_fire),  32'(m_fire));
    chk("m.busy_vec",    busy_vec,         m_busy);
    chk("m.pending_cnt", 32'(pending_cnt), 32'($countones(m_busy)));
    chk("m.drain_done",  32'(drain_done),  32'(m_state == M_HALT));
    chk("m.timeout",     32'(timeout),     32'(m_to));
  end

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] dst, input logic wr);
    issue_valid = v; issue_rs = rs; issue_rt = rt;
    issue_uses_rt = urt; issue_dest = dst; issue_writes = wr;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    wb_valid = 1'b0; flush = 1'b0; drain_req = 1'b0; resume = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 0; wb_dest = 0; flush = 0; drain_req = 0; resume = 0;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.fire", 32'(issue_fire), 32'd0);
    chk("rst.busy", busy_vec, 32'd0);
    chk("rst.pend", 32'(pending_cnt), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1; reset = 1'b0; drive(0, 0, 0, 0, 0, 0);
    cyc();

    // RAW on r5: stall until the cycle after its write-back
    drive(1, 1, 2, 0, 5, 1); @(negedge clk); chk("raw.fire0", 32'(issue_fire), 32'd1); cyc();
    drive(1, 5, 0, 0, 0, 0); @(negedge clk); chk("raw.stall", 32'(stall), 32'd1);
    chk("raw.busy", busy_vec, 32'h20); chk("raw.pend", 32'(pending_cnt), 32'd1); cyc();
    wb_valid = 1; wb_dest = 5; @(negedge clk); chk("raw.nobypass", 32'(stall), 32'd1); cyc();
    @(negedge clk); chk("raw.unstall", 32'(stall), 32'd0);
    chk("raw.fire1", 32'(issue_fire), 32'd1); drive(0, 0, 0, 0, 0, 0); cyc();

    // r0 is never tracked
    drive(1, 0, 0, 0, 0, 1); @(negedge clk); chk("r0.fire", 32'(issue_fire), 32'd1); cyc();
    @(negedge clk); chk("r0.stall", 32'(stall), 32'd0); chk("r0.busy", busy_vec, 32'd0);
    drive(0, 0, 0, 0, 0, 0); cyc();

    // Drain with r3/r7 outstanding, halt, resume
    drive(1, 0, 0, 0, 3, 1); cyc();
    drive(1, 0, 0, 0, 7, 1); cyc();
    drive(0, 0, 0, 0, 0, 0); drain_req = 1; @(negedge clk);
    chk("drn.busy", busy_vec, 32'h88); chk("drn.pend", 32'(pending_cnt), 32'd2); cyc();
    drive(1, 0, 0, 0, 0, 0); wb_valid = 1; wb_dest = 3; @(negedge clk);
    chk("drn.stall", 32'(stall), 32'd1); chk("drn.nofire", 32'(issue_fire), 32'd0); cyc();
    wb_valid = 1; wb_dest = 7; @(negedge clk); chk("drn.done0", 32'(drain_done), 32'd0); cyc();
    @(negedge clk); chk("drn.empty", busy_vec, 32'd0); chk("drn.done1", 32'(drain_done), 32'd0); cyc();
    @(negedge clk); chk("drn.halted", 32'(drain_done), 32'd1); chk("drn.hstall", 32'(stall), 32'd1);
    resume = 1; drain_req = 1; cyc();
    @(negedge clk); chk("drn.run", 32'(drain_done), 32'd0); chk("drn.refire", 32'(issue_fire), 32'd1);
    drive(0, 0, 0, 0, 0, 0); cyc();

    // Flush beats a same-cycle set
    drive(1, 0, 0, 0, 9, 1); cyc();
    drive(1, 0, 0, 0, 4, 1); flush = 1; @(negedge clk); chk("fl.busy9", busy_vec, 32'h200); cyc();
    drive(0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("fl.busy", busy_vec, 32'd0); chk("fl.pend", 32'(pending_cnt), 32'd0); cyc();

    // Watchdog: timeout after the 4th consecutive stalled cycle, sticky
    drive(1, 0, 0, 0, 12, 1); cyc();
    drive(1, 12, 0, 0, 0, 0); @(negedge clk); chk("wd.t0", 32'(timeout), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(); @(negedge clk); chk("wd.tn", 32'(timeout), 32'(i >= 4));
    end
    wb_valid = 1; wb_dest = 12; cyc();
    @(negedge clk); chk("wd.fire", 32'(issue_fire), 32'd1); chk("wd.sticky", 32'(timeout), 32'd1);
    drive(0, 0, 0, 0, 0, 0); cyc();
    @(negedge clk); chk("wd.sticky2", 32'(timeout), 32'd1);

    // Asynchronous reset in the middle of a drain
    drive(1, 0, 0, 0, 20, 1); cyc();
    drive(0, 0, 0, 0, 0, 0); drain_req = 1; cyc();
    drive(1, 0, 0, 0, 0, 0); @(negedge clk);
    chk("ar.pre_stall", 32'(stall), 32'd1); chk("ar.pre_busy", busy_vec, 32'h0010_0000);
    #2 reset = 1'b1; #1;
    chk("ar.busy", busy_vec, 32'd0); chk("ar.pend", 32'(pending_cnt), 32'd0);
    chk("ar.stall", 32'(stall), 32'd0); chk("ar.fire", 32'(issue_fire), 32'd0);
    chk("ar.done", 32'(drain_done), 32'd0); chk("ar.timeout", 32'(timeout), 32'd0);
    @(posedge clk); #3; reset = 1'b0;
    @(negedge clk); chk("ar.run_fire", 32'(issue_fire), 32'd1);
    drive(0, 0, 0, 0, 0, 0); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter STALL_LIMIT, default 255, meaning the number of consecutive stalled cycles before timeout is raised (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port issue_valid, input, 1, decode holds an instruction.
REQ-005 The block SHALL have ports issue_rs and issue_rt, input, 5 each, source register addresses.
REQ-006 The block SHALL have port issue_uses_rt, input, 1, rt is a true source (R-type).
REQ-007 The block SHALL have port issue_dest, input, 5, destination register.
REQ-008 The block SHALL have port issue_writes, input, 1, instruction writes issue_dest.
REQ-009 The block SHALL have ports wb_valid, input, 1, and wb_dest, input, 5, write-back retiring a register.
REQ-010 The block SHALL have ports flush, input, 1, drain_req, input, 1, and resume, input, 1, as control pulses.
REQ-011 The block SHALL have port stall, output, 1, hold decode/ID-EX this cycle.
REQ-012 The block SHALL have port issue_fire, output, 1, instruction accepted this cycle.
REQ-013 The block SHALL have port busy_vec, output, 32, per-register pending-write bits.
REQ-014 The block SHALL have port pending_cnt, output, 6, population count of busy_vec.
REQ-015 The block SHALL have ports drain_done, output, 1, and timeout, output, 1, status flags.

Function
REQ-016 The block SHALL implement FSM states RUN, DRAIN and HALTED.
REQ-017 The FSM SHALL move RUN->DRAIN on drain_req, DRAIN->HALTED when busy_vec==0 at a clock edge, and HALTED->RUN on resume; drain_req and resume SHALL be ignored in other states.
REQ-018 hazard SHALL be combinational: (rs!=0 & busy_vec[rs]) | (issue_uses_rt & rt!=0 & busy_vec[rt]) | (issue_writes & dest!=0 & busy_vec[dest]).
REQ-019 stall SHALL equal issue_valid & (hazard | state!=RUN).
REQ-020 issue_fire SHALL equal issue_valid & ~stall.
REQ-021 On issue_fire & issue_writes & dest!=0, busy_vec[dest] SHALL set at the next edge.
REQ-022 On wb_valid & wb_dest!=0, busy_vec[wb_dest] SHALL clear at the next edge.
REQ-023 The hazard check SHALL use registered busy_vec only, with no write-back bypass, so a cleared register unstalls one cycle after wb_valid, matching register-file write-then-read timing.
REQ-024 busy_vec[0] SHALL be constant 0.
REQ-025 If a set and a clear target the same register in one cycle, the set SHALL win.
REQ-026 flush SHALL clear busy_vec and the watchdog counter at the next edge, override same-cycle sets and clears, and leave the FSM state unchanged.
REQ-027 pending_cnt SHALL be registered and track busy_vec in the same cycle.
REQ-028 drain_done SHALL be 1 exactly while state==HALTED.
REQ-029 The watchdog counter SHALL increment on each cycle with state==RUN & stall, reset to 0 otherwise, and saturate at STALL_LIMIT.
REQ-030 timeout SHALL set when the watchdog counter reaches STALL_LIMIT and stay set (sticky) until reset.

Reset
REQ-031 On reset the block SHALL set state=RUN, busy_vec=0, pending_cnt=0, watchdog=0, timeout=0 and drain_done=0, regardless of any operation in progress.
REQ-032 While reset is asserted, stall and issue_fire SHALL be 0.

Structure
REQ-033 The state enum, register-address width (5) and register count (32) SHALL live in the shared mips_pkg package.
REQ-034 The watchdog SHALL be a sub-module, stall_watchdog, with parameter STALL_LIMIT and ports clk, reset, count_en, clr and timeout.

Verification
REQ-035 The bench SHALL check this scenario: issue dest=5 writes, then next cycle rs=5 -> stall=1 until the cycle after wb_valid/wb_dest=5, then issue_fire=1.
REQ-036 The bench SHALL check this scenario: issue dest=0 writes, then rs=0 -> no stall and busy_vec stays 0.
REQ-037 The bench SHALL check this scenario: busy_vec={3,7} then drain_req -> stall=1 and state DRAIN; wb 3 and wb 7 -> drain_done=1 the edge after busy_vec==0; resume -> RUN.
REQ-038 The bench SHALL check this scenario: busy_vec[9]=1 and flush with a same-cycle issue of dest=4 -> busy_vec==0 and pending_cnt==0 next cycle.
REQ-039 The bench SHALL check this scenario: STALL_LIMIT=4, rs held on a busy register -> timeout=1 after the 4th stalled cycle and remains 1 after the write-back.
REQ-040 The bench SHALL check this scenario: reset asserted mid-DRAIN with busy_vec!=0 -> all outputs return to reset values asynchronously.
